// File: rtl/screens_sequencer_pkg.sv
// Shared game types: screen-select encoding and default frame timing constants.
// Imported by the screen modules; holds no logic.
package screens_sequencer_pkg;

    typedef enum logic [1:0] {
        SCREEN_WELCOME   = 2'd0,
        SCREEN_MAIN      = 2'd1,
        SCREEN_GAME_OVER = 2'd2
    } screen_sel_t;

    localparam int DEFAULT_GAME_OVER_FRAMES     = 180;
    localparam int DEFAULT_START_LOCKOUT_FRAMES = 8;

    // One spare bit above the larger frame limit so saturation never aliases it.
    function automatic int frame_cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/key_edge_detector.sv
// Rising-edge detector for a level key. The pulse is registered, so it appears 1 cycle after the key rises.
// No backpressure: a held key yields exactly one pulse.
module key_edge_detector (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_rise
);

    logic r_prev;
    logic r_rise;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_prev <= i_key;
            r_rise <= i_key & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/screens_sequencer.sv
// Game screen sequencer: WELCOME -> MAIN -> GAME_OVER. Outputs are registered; key events lag the keys by 1 cycle.
// No backpressure: key events that arrive while they are not accepted are dropped.
module screens_sequencer
    import screens_sequencer_pkg::*;
#(
    parameter int GAME_OVER_FRAMES     = DEFAULT_GAME_OVER_FRAMES,
    parameter int START_LOCKOUT_FRAMES = DEFAULT_START_LOCKOUT_FRAMES
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        key5IsPressed,
    input  logic        key4IsPressed,
    input  logic        key6IsPressed,
    input  logic [3:0]  life,
    input  logic [15:0] score,
    output logic        start,
    output logic [1:0]  screenSel,
    output logic        flipperType,
    output logic [15:0] highScore,
    output logic        newRecord
);

    localparam int CW = frame_cnt_width(GAME_OVER_FRAMES, START_LOCKOUT_FRAMES);
    localparam logic [CW-1:0] LOCK_DONE = CW'(START_LOCKOUT_FRAMES);
    localparam logic [CW-1:0] GO_LAST   = CW'(GAME_OVER_FRAMES - 1);
    localparam logic [CW-1:0] CNT_SAT   = '1;

    screen_sel_t r_state;
    screen_sel_t w_next_state;
    logic        w_k4;
    logic        w_k5;
    logic        w_k6;
    logic        w_start;
    logic        w_go_enter;
    logic        w_go_exit;
    logic        r_start;
    logic        r_armed;
    logic        r_flipper;
    logic        r_new_record;
    logic [15:0] r_high_score;
    logic [15:0] r_final_score;
    logic [CW-1:0] r_lock_cnt;
    logic [CW-1:0] r_frame_cnt;

    key_edge_detector u_key4 (.i_clk(clk), .i_rst_n(resetN), .i_key(key4IsPressed), .o_rise(w_k4));
    key_edge_detector u_key5 (.i_clk(clk), .i_rst_n(resetN), .i_key(key5IsPressed), .o_rise(w_k5));
    key_edge_detector u_key6 (.i_clk(clk), .i_rst_n(resetN), .i_key(key6IsPressed), .o_rise(w_k6));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= SCREEN_WELCOME;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_go_enter   = 1'b0;
        w_go_exit    = 1'b0;
        case (r_state)
            SCREEN_WELCOME: begin
                // The registered count only reaches LOCK_DONE after the expiring frame, so a coincident press is dropped.
                if (w_k5 && (r_lock_cnt >= LOCK_DONE)) begin
                    w_next_state = SCREEN_MAIN;
                    w_start      = 1'b1;
                end
            end
            SCREEN_MAIN: begin
                if (r_armed && (life == 4'd0)) begin
                    w_next_state = SCREEN_GAME_OVER;
                    w_go_enter   = 1'b1;
                end
            end
            SCREEN_GAME_OVER: begin
                if (startOfFrame && (r_frame_cnt >= GO_LAST)) begin
                    w_next_state = SCREEN_WELCOME;
                    w_go_exit    = 1'b1;
                end
            end
            default: w_next_state = SCREEN_WELCOME;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_start       <= 1'b0;
            r_armed       <= 1'b0;
            r_flipper     <= 1'b0;
            r_new_record  <= 1'b0;
            r_high_score  <= '0;
            r_final_score <= '0;
            r_lock_cnt    <= '0;
            r_frame_cnt   <= '0;
        end else begin
            r_start <= w_start;

            if (w_go_exit) begin
                r_lock_cnt <= '0;
            end else if ((r_state == SCREEN_WELCOME) && startOfFrame && (r_lock_cnt != CNT_SAT)) begin
                r_lock_cnt <= r_lock_cnt + CW'(1);
            end

            if (w_go_exit) begin
                r_frame_cnt <= '0;
            end else if ((r_state == SCREEN_GAME_OVER) && startOfFrame && (r_frame_cnt != CNT_SAT)) begin
                r_frame_cnt <= r_frame_cnt + CW'(1);
            end

            if (w_start) begin
                r_armed <= 1'b0;
            end else if ((r_state == SCREEN_MAIN) && (life != 4'd0)) begin
                r_armed <= 1'b1;
            end

            if ((r_state == SCREEN_WELCOME) && (w_k4 != w_k6)) begin
                r_flipper <= w_k6;
            end

            if (w_go_enter) begin
                r_final_score <= score;
                r_new_record  <= (score > r_high_score);
            end else if (w_go_exit) begin
                if (r_new_record) begin
                    r_high_score <= r_final_score;
                end
                r_new_record <= 1'b0;
            end
        end
    end

    // A record is committed to r_high_score on leaving GAME_OVER; until then the final score stands in for it.
    assign highScore   = r_new_record ? r_final_score : r_high_score;
    assign start       = r_start;
    assign screenSel   = r_state;
    assign flipperType = r_flipper;
    assign newRecord   = r_new_record;

endmodule
